// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage core: opcodes, NOP encoding,
// register-read decode helpers and the hazard controller state type.
package cpu_pkg;

    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_NOP  = 4'hF;

    localparam logic [15:0] NOP_INST = 16'hF000;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        MEM_WAIT = 2'd3
    } hz_state_t;

    // ALU ops, LW and SW all read rs.
    function automatic logic uses_rs(input logic [3:0] opcode);
        return opcode <= OP_SW;
    endfunction

    // Only the two-register ALU ops (0x0-0x3) read rt.
    function automatic logic uses_rt(input logic [3:0] opcode);
        return opcode <= 4'h3;
    endfunction

    // SW reads its store data from rd; LHB/LLB merge into the old rd value.
    function automatic logic uses_rd(input logic [3:0] opcode);
        return (opcode == OP_SW) || (opcode == OP_LHB) || (opcode == OP_LLB);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a LW in EX whose destination is a
// register actually read by the instruction in ID.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [3:0] ex_rd,
    input  logic [3:0] id_opcode,
    input  logic [3:0] id_rs,
    input  logic [3:0] id_rt,
    input  logic [3:0] id_rd,
    output logic       lu
);

    logic src_match;

    always_comb begin
        // NOP decodes as reading nothing, so it can never match.
        src_match = (uses_rs(id_opcode) && (id_rs == ex_rd)) ||
                    (uses_rt(id_opcode) && (id_rt == ex_rd)) ||
                    (uses_rd(id_opcode) && (id_rd == ex_rd));
        lu = ex_mem_read && (ex_rd != 4'd0) && src_match;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sequences load-use stalls, redirect bubbles and
// data-memory freezes, and keeps a saturating stall-cycle counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned LOAD_USE_CYCLES  = 1,
    parameter int unsigned REDIRECT_BUBBLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  id_rd,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_stall,
    output logic        idex_flush,
    output logic        exmem_stall,
    output logic [15:0] stall_count
);

    localparam logic [1:0] LU_RELOAD = 2'(LOAD_USE_CYCLES - 1);
    localparam logic [1:0] RD_RELOAD = 2'(REDIRECT_BUBBLES - 1);

    hz_state_t  state, state_nxt;
    hz_state_t  ret_st, ret_nxt;
    hz_state_t  eff_st;
    logic [1:0] cnt, cnt_nxt;
    logic       lu;

    load_use_detect u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .lu          (lu)
    );

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        pc_write    = 1'b1;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        // Leaving MEM_WAIT resumes the saved state in the very cycle mem_busy falls.
        eff_st      = (state == MEM_WAIT) ? ret_st : state;
        state_nxt   = eff_st;
        ret_nxt     = ret_st;
        cnt_nxt     = cnt;

        if (rst) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_nxt  = RUN;
            ret_nxt    = RUN;
            cnt_nxt    = 2'd0;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            state_nxt   = MEM_WAIT;
            ret_nxt     = eff_st;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = RD_RELOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        end else begin
            unique case (eff_st)
                LU_STALL: begin
                    pc_write   = 1'b0;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    if (cnt <= 2'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    if (lu) begin
                        pc_write   = 1'b0;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_nxt = LU_STALL;
                            cnt_nxt   = LU_RELOAD;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            ret_st      <= RUN;
            cnt         <= 2'd0;
            stall_count <= 16'd0;
        end else begin
            state  <= state_nxt;
            ret_st <= ret_nxt;
            cnt    <= cnt_nxt;
            if (!pc_write && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two hazard_ctrl instances with different bubble counts
// share one stimulus stream and are compared against a remaining-bubbles model.
module tb_hazard_ctrl;

    localparam int LU_A = 1;
    localparam int RB_A = 2;
    localparam int LU_B = 3;
    localparam int RB_B = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_busy = 1'b0;
    logic       ex_redirect = 1'b0;
    logic       ex_mem_read = 1'b0;
    logic [3:0] ex_rd = 4'd0;
    logic [3:0] id_opcode = 4'hF;
    logic [3:0] id_rs = 4'd0;
    logic [3:0] id_rt = 4'd0;
    logic [3:0] id_rd = 4'd0;

    logic        pc_write_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a, exmem_stall_a;
    logic        pc_write_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b, exmem_stall_b;
    logic [15:0] stall_count_a, stall_count_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_CYCLES(LU_A), .REDIRECT_BUBBLES(RB_A)) dut_a (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_write(pc_write_a), .ifid_stall(ifid_stall_a), .ifid_flush(ifid_flush_a),
        .idex_stall(idex_stall_a), .idex_flush(idex_flush_a), .exmem_stall(exmem_stall_a),
        .stall_count(stall_count_a)
    );

    hazard_ctrl #(.LOAD_USE_CYCLES(LU_B), .REDIRECT_BUBBLES(RB_B)) dut_b (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
        .pc_write(pc_write_b), .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b),
        .idex_stall(idex_stall_b), .idex_flush(idex_flush_b), .exmem_stall(exmem_stall_b),
        .stall_count(stall_count_b)
    );

    // Control vector order: {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
    logic [5:0]  obs_ctl [2];
    logic [15:0] obs_cnt [2];
    assign obs_ctl[0] = {pc_write_a, ifid_stall_a, ifid_flush_a, idex_stall_a, idex_flush_a, exmem_stall_a};
    assign obs_ctl[1] = {pc_write_b, ifid_stall_b, ifid_flush_b, idex_stall_b, idex_flush_b, exmem_stall_b};
    assign obs_cnt[0] = stall_count_a;
    assign obs_cnt[1] = stall_count_b;

    localparam logic [5:0] CTL_RESET  = 6'b001010;
    localparam logic [5:0] CTL_FREEZE = 6'b010101;
    localparam logic [5:0] CTL_REDIR  = 6'b101010;
    localparam logic [5:0] CTL_FLUSH  = 6'b101000;
    localparam logic [5:0] CTL_LU     = 6'b010010;
    localparam logic [5:0] CTL_NORMAL = 6'b100000;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: bubbles still owed after the current cycle, and the counter value.
    int lu_len [2] = '{LU_A, LU_B};
    int rb_len [2] = '{RB_A, RB_B};
    int lu_left [2] = '{0, 0};
    int fl_left [2] = '{0, 0};
    int cnt_m   [2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hazard();
        bit hz = 1'b0;
        int op = int'(id_opcode);
        if (!ex_mem_read || ex_rd == 4'd0) return 1'b0;
        if (op <= 9 && id_rs == ex_rd) hz = 1'b1;
        if (op <= 3 && id_rt == ex_rd) hz = 1'b1;
        if ((op == 9 || op == 10 || op == 11) && id_rd == ex_rd) hz = 1'b1;
        return hz;
    endfunction

    task automatic model_step(input int i, output logic [5:0] exp_ctl);
        if (rst) begin
            exp_ctl = CTL_RESET;
            lu_left[i] = 0;
            fl_left[i] = 0;
        end else if (mem_busy) begin
            exp_ctl = CTL_FREEZE;
        end else if (ex_redirect) begin
            exp_ctl = CTL_REDIR;
            fl_left[i] = rb_len[i] - 1;
            lu_left[i] = 0;
        end else if (fl_left[i] > 0) begin
            exp_ctl = CTL_FLUSH;
            fl_left[i]--;
        end else if (lu_left[i] > 0) begin
            exp_ctl = CTL_LU;
            lu_left[i]--;
        end else if (model_hazard()) begin
            exp_ctl = CTL_LU;
            lu_left[i] = lu_len[i] - 1;
        end else begin
            exp_ctl = CTL_NORMAL;
        end
    endtask

    // One clock cycle: apply inputs just after posedge, compare on the negedge.
    task automatic drive(input logic r, input logic mb, input logic redir, input logic mr,
                         input logic [3:0] erd, input logic [3:0] op,
                         input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rdf);
        logic [5:0] exp_ctl;
        @(posedge clk);
        #1;
        rst = r; mem_busy = mb; ex_redirect = redir; ex_mem_read = mr;
        ex_rd = erd; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rdf;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            model_step(i, exp_ctl);
            check($sformatf("ctl_%0d", i), 32'(obs_ctl[i]), 32'(exp_ctl));
            check($sformatf("stall_count_%0d", i), 32'(obs_cnt[i]), cnt_m[i]);
            if (rst) cnt_m[i] = 0;
            else if (!exp_ctl[5] && cnt_m[i] < 65535) cnt_m[i]++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
        drive(1, 0, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
        idle(2);

        // Load-use: LW R3 in EX, ADD R?,R3,R? in ID
        drive(0, 0, 0, 1, 4'd3, 4'h0, 4'd3, 4'd1, 4'd2);
        idle(4);
        check("lu_count_a", 32'(stall_count_a), 32'd1);
        check("lu_count_b", 32'(stall_count_b), 32'd3);

        // Load-use negatives: R0 destination, INC reading only rs
        drive(0, 0, 0, 1, 4'd0, 4'h0, 4'd0, 4'd0, 4'd0);
        drive(0, 0, 0, 1, 4'd5, 4'h4, 4'd1, 4'd5, 4'd5);
        // SW store data in rd and LHB in rd do hazard
        drive(0, 0, 0, 1, 4'd6, 4'h9, 4'd1, 4'd2, 4'd6);
        idle(4);
        drive(0, 0, 0, 1, 4'd7, 4'hA, 4'd1, 4'd2, 4'd7);
        idle(4);
        // NOP never hazards
        drive(0, 0, 0, 1, 4'd1, 4'hF, 4'd1, 4'd1, 4'd1);

        // Redirect, then back-to-back redirect while flushing
        drive(0, 0, 1, 0, 4'd0, 4'hC, 4'd0, 4'd0, 4'd0);
        idle(4);
        drive(0, 0, 1, 0, 4'd0, 4'hD, 4'd0, 4'd0, 4'd0);
        drive(0, 0, 1, 0, 4'd0, 4'hE, 4'd0, 4'd0, 4'd0);
        idle(4);

        // Memory wait in the middle of a load-use stall, with a coinciding redirect
        drive(0, 0, 0, 1, 4'd2, 4'h1, 4'd0, 4'd2, 4'd0);
        drive(0, 1, 0, 0, 4'd0, 4'h1, 4'd0, 4'd2, 4'd0);
        drive(0, 1, 1, 0, 4'd0, 4'h1, 4'd0, 4'd2, 4'd0);
        drive(0, 1, 0, 0, 4'd0, 4'h1, 4'd0, 4'd2, 4'd0);
        idle(5);

        // Reset mid-FLUSH
        drive(0, 0, 1, 0, 4'd0, 4'hC, 4'd0, 4'd0, 4'd0);
        drive(1, 0, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
        idle(3);
        check("rst_count_a", 32'(stall_count_a), 32'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end

        // Saturation through a long memory freeze
        drive(1, 0, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
        for (int k = 0; k < 65540; k++) drive(0, 1, 0, 0, 4'd0, 4'hF, 4'd0, 4'd0, 4'd0);
        idle(2);
        check("sat_a", 32'(stall_count_a), 32'hFFFF);
        check("sat_b", 32'(stall_count_b), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
